// File: rtl/ducks_sprite_fetch_if.sv
// Scan-position, per-frame sprite control, index ROM and palette-index bus
// between the VGA timing/controller side and the duck sprite fetcher.
interface ducks_sprite_fetch_if #(
   parameter int ADDR_W = 13
);
   logic [9:0]        DrawX;
   logic [9:0]        DrawY;
   logic              blank;
   logic              frame_start;
   logic [9:0]        duck_x;
   logic [9:0]        duck_y;
   logic              duck_en;
   logic              duck_mirror;
   logic [ADDR_W-1:0] rom_addr;
   logic [3:0]        rom_data;
   logic [3:0]        pixel_index;
   logic              pixel_opaque;
   logic [1:0]        anim_frame;

   modport master (
      output DrawX, DrawY, blank, frame_start,
      output duck_x, duck_y, duck_en, duck_mirror,
      output rom_data,
      input  rom_addr, pixel_index, pixel_opaque, anim_frame
   );

   modport slave (
      input  DrawX, DrawY, blank, frame_start,
      input  duck_x, duck_y, duck_en, duck_mirror,
      input  rom_data,
      output rom_addr, pixel_index, pixel_opaque, anim_frame
   );
endinterface

// File: rtl/ducks_sprite_fetch.sv
// Duck sprite address generator and index fetcher: scan position -> sync ROM
// address -> registered palette index/opaque flag, fixed 3-cycle latency.
module ducks_sprite_fetch #(
   parameter int SPR_W       = 50,
   parameter int SPR_H       = 50,
   parameter int ANIM_FRAMES = 3,
   parameter int ANIM_DIV    = 8,
   parameter int ADDR_W      = 13,
   parameter int TRANSP_IDX  = 0
) (
   input  logic                      Clk,
   input  logic                      Reset,
   ducks_sprite_fetch_if.slave       bus
);

   localparam int DIV_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam int FRAME_SZ = SPR_W * SPR_H;
   localparam logic [3:0] TRANSP = 4'(TRANSP_IDX);

   // Linear ROM address of one sprite texel; arithmetic wraps at ADDR_W bits.
   function automatic logic [ADDR_W-1:0] sprite_addr(
      input logic [1:0]  anim,
      input logic [10:0] dy,
      input logic [10:0] col
   );
      sprite_addr = ADDR_W'(anim) * ADDR_W'(FRAME_SZ)
                  + ADDR_W'(dy) * ADDR_W'(SPR_W)
                  + ADDR_W'(col);
   endfunction

   logic [9:0]        lx_r;
   logic [9:0]        ly_r;
   logic              en_r;
   logic              mir_r;
   logic [DIV_W-1:0]  div_r;
   logic [1:0]        anim_r;
   logic [ADDR_W-1:0] rom_addr_r;
   logic              hit1_r;
   logic              hit2_r;
   logic [3:0]        idx_r;
   logic              opq_r;

   logic [10:0]       x_s;
   logic [10:0]       y_s;
   logic [10:0]       lx_s;
   logic [10:0]       ly_s;
   logic [10:0]       x_end_s;
   logic [10:0]       y_end_s;
   logic [10:0]       dx_s;
   logic [10:0]       dy_s;
   logic [10:0]       col_s;
   logic              hit_s;
   logic [ADDR_W-1:0] addr_s;

   // Per-frame latch of sprite placement; the current cycle still sees old values.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         lx_r  <= 10'd0;
         ly_r  <= 10'd0;
         en_r  <= 1'b0;
         mir_r <= 1'b0;
      end else if (bus.frame_start) begin
         lx_r  <= bus.duck_x;
         ly_r  <= bus.duck_y;
         en_r  <= bus.duck_en;
         mir_r <= bus.duck_mirror;
      end else begin
         lx_r  <= lx_r;
         ly_r  <= ly_r;
         en_r  <= en_r;
         mir_r <= mir_r;
      end
   end

   // Animation step: only moves at frame_start, so a visible frame never tears.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         div_r  <= {DIV_W{1'b0}};
         anim_r <= 2'd0;
      end else if (bus.frame_start) begin
         if (div_r == DIV_W'(ANIM_DIV - 1)) begin
            div_r  <= {DIV_W{1'b0}};
            anim_r <= (anim_r == 2'(ANIM_FRAMES - 1)) ? 2'd0 : anim_r + 2'd1;
         end else begin
            div_r  <= div_r + DIV_W'(1);
            anim_r <= anim_r;
         end
      end else begin
         div_r  <= div_r;
         anim_r <= anim_r;
      end
   end

   // Stage 0: 11-bit box test so a sprite past column/row 1023 clips instead of wrapping.
   always_comb begin
      x_s     = {1'b0, bus.DrawX};
      y_s     = {1'b0, bus.DrawY};
      lx_s    = {1'b0, lx_r};
      ly_s    = {1'b0, ly_r};
      x_end_s = lx_s + 11'(SPR_W);
      y_end_s = ly_s + 11'(SPR_H);
      hit_s   = bus.blank & en_r
              & (x_s >= lx_s) & (x_s < x_end_s)
              & (y_s >= ly_s) & (y_s < y_end_s);
      dx_s    = x_s - lx_s;
      dy_s    = y_s - ly_s;
      col_s   = mir_r ? (11'(SPR_W - 1) - dx_s) : dx_s;
      addr_s  = sprite_addr(anim_r, dy_s, col_s);
   end

   // Stage 1: address only updates on a hit to keep the ROM bus quiet elsewhere.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rom_addr_r <= {ADDR_W{1'b0}};
         hit1_r     <= 1'b0;
      end else if (hit_s) begin
         rom_addr_r <= addr_s;
         hit1_r     <= 1'b1;
      end else begin
         rom_addr_r <= rom_addr_r;
         hit1_r     <= 1'b0;
      end
   end

   // Stages 2/3: align hit with ROM data, then register the palette outputs.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         hit2_r <= 1'b0;
         idx_r  <= 4'd0;
         opq_r  <= 1'b0;
      end else begin
         hit2_r <= hit1_r;
         idx_r  <= hit2_r ? bus.rom_data : TRANSP;
         opq_r  <= hit2_r & (bus.rom_data != TRANSP);
      end
   end

   assign bus.rom_addr     = rom_addr_r;
   assign bus.pixel_index  = idx_r;
   assign bus.pixel_opaque = opq_r;
   assign bus.anim_frame   = anim_r;

endmodule

// File: tb/tb_ducks_sprite_fetch.sv
// Bench for ducks_sprite_fetch: directed scenarios plus randomized scans,
// compared against a frame-count/box-arithmetic reference model.
module tb_ducks_sprite_fetch;

   localparam int SPR_W = 50;
   localparam int SPR_H = 50;
   localparam int ANIM_FRAMES = 3;
   localparam int ANIM_DIV = 8;
   localparam int ADDR_W = 13;

   logic Clk;
   logic Reset;

   ducks_sprite_fetch_if #(.ADDR_W(ADDR_W)) bus ();

   ducks_sprite_fetch #(
      .SPR_W(SPR_W), .SPR_H(SPR_H), .ANIM_FRAMES(ANIM_FRAMES),
      .ANIM_DIV(ANIM_DIV), .ADDR_W(ADDR_W), .TRANSP_IDX(0)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .bus(bus)
   );

   int rom [0:(1<<ADDR_W)-1];
   int n_vec = 0;
   int n_err = 0;

   // reference state: latched placement and number of frame_starts since reset
   int m_lx, m_ly, m_en, m_mir, m_pulses, m_addr;
   int q_idx[$];
   int q_opq[$];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // synchronous index ROM: data valid one cycle after the address
   always @(posedge Clk) bus.rom_data <= 4'(rom[bus.rom_addr]);

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int m_anim();
      return (m_pulses / ANIM_DIV) % ANIM_FRAMES;
   endfunction

   task automatic cycle(input int x, input int y, input bit bl, input bit fs);
      bit hit;
      int col, addr, eidx, oi, oo;
      bus.DrawX = 10'(x);
      bus.DrawY = 10'(y);
      bus.blank = bl;
      bus.frame_start = fs;
      hit = bl && (m_en != 0) && x >= m_lx && x < m_lx + SPR_W
                 && y >= m_ly && y < m_ly + SPR_H;
      col  = (m_mir != 0) ? (SPR_W - 1 - (x - m_lx)) : (x - m_lx);
      addr = (m_anim() * SPR_W * SPR_H + (y - m_ly) * SPR_W + col) % (1 << ADDR_W);
      eidx = hit ? rom[addr] : 0;
      if (hit) m_addr = addr;
      q_idx.push_back(eidx);
      q_opq.push_back((hit && eidx != 0) ? 1 : 0);
      if (fs) begin
         m_lx = int'(bus.duck_x);
         m_ly = int'(bus.duck_y);
         m_en = int'(bus.duck_en);
         m_mir = int'(bus.duck_mirror);
         m_pulses++;
      end
      @(negedge Clk);
      oi = q_idx.pop_front();
      oo = q_opq.pop_front();
      chk("rom_addr", int'(bus.rom_addr), m_addr);
      chk("anim_frame", int'(bus.anim_frame), m_anim());
      chk("pixel_index", int'(bus.pixel_index), oi);
      chk("pixel_opaque", int'(bus.pixel_opaque), oo);
   endtask

   task automatic idle();
      cycle(0, 0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset = 1'b1;
      #1;
      chk("rst_addr", int'(bus.rom_addr), 0);
      chk("rst_index", int'(bus.pixel_index), 0);
      chk("rst_opaque", int'(bus.pixel_opaque), 0);
      chk("rst_anim", int'(bus.anim_frame), 0);
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      m_lx = 0; m_ly = 0; m_en = 0; m_mir = 0; m_pulses = 0; m_addr = 0;
      q_idx.delete();
      q_opq.delete();
      repeat (2) begin
         q_idx.push_back(0);
         q_opq.push_back(0);
      end
   endtask

   initial begin
      Reset = 1'b0;
      bus.DrawX = 10'd0; bus.DrawY = 10'd0; bus.blank = 1'b0; bus.frame_start = 1'b0;
      bus.duck_x = 10'd0; bus.duck_y = 10'd0; bus.duck_en = 1'b0; bus.duck_mirror = 1'b0;
      for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = int'($urandom_range(1, 15));
      for (int i = 0; i < 400; i++) rom[$urandom_range(0, 7499)] = 0;
      rom[0] = 3;
      rom[505] = 0;

      do_reset();

      // basic placement and first-pixel latency
      bus.duck_x = 10'd100; bus.duck_y = 10'd200; bus.duck_en = 1'b1; bus.duck_mirror = 1'b0;
      cycle(0, 0, 1'b0, 1'b1);
      cycle(100, 200, 1'b1, 1'b0);
      chk("tp_addr_origin", int'(bus.rom_addr), 0);
      idle();
      chk("tp_opq_early", int'(bus.pixel_opaque), 0);
      idle();
      chk("tp_idx_origin", int'(bus.pixel_index), 3);
      chk("tp_opq_origin", int'(bus.pixel_opaque), 1);
      cycle(149, 249, 1'b1, 1'b0);
      chk("tp_addr_corner", int'(bus.rom_addr), 2499);
      cycle(150, 249, 1'b1, 1'b0);
      idle(); idle();
      chk("tp_idx_right_edge", int'(bus.pixel_index), 0);
      chk("tp_opq_right_edge", int'(bus.pixel_opaque), 0);
      cycle(100, 250, 1'b1, 1'b0);
      idle(); idle();
      chk("tp_opq_bottom_edge", int'(bus.pixel_opaque), 0);

      // mirrored sprite
      bus.duck_mirror = 1'b1;
      cycle(0, 0, 1'b0, 1'b1);
      cycle(100, 201, 1'b1, 1'b0);
      chk("tp_mirror_left", int'(bus.rom_addr), 99);
      cycle(149, 201, 1'b1, 1'b0);
      chk("tp_mirror_right", int'(bus.rom_addr), 50);

      // animation divider: 8 pulses per frame step, 3 frames
      bus.duck_mirror = 1'b0;
      repeat (6) cycle(0, 0, 1'b0, 1'b1);
      chk("tp_anim_step", int'(bus.anim_frame), 1);
      cycle(100, 200, 1'b1, 1'b0);
      chk("tp_anim_addr", int'(bus.rom_addr), 2500);
      repeat (16) cycle(0, 0, 1'b0, 1'b1);
      chk("tp_anim_wrap", int'(bus.anim_frame), 0);

      // right-edge clipping, blanking and transparent index
      bus.duck_x = 10'd1000;
      cycle(0, 0, 1'b0, 1'b1);
      cycle(1023, 210, 1'b1, 1'b0);
      chk("tp_clip_hit", int'(bus.rom_addr), 523);
      cycle(5, 210, 1'b1, 1'b0);
      chk("tp_no_wrap_addr", int'(bus.rom_addr), 523);
      idle(); idle();
      chk("tp_no_wrap_opq", int'(bus.pixel_opaque), 0);
      cycle(1010, 210, 1'b0, 1'b0);
      idle(); idle();
      chk("tp_blank_opq", int'(bus.pixel_opaque), 0);
      cycle(1005, 210, 1'b1, 1'b0);
      chk("tp_transp_addr", int'(bus.rom_addr), 505);
      idle(); idle();
      chk("tp_transp_opq", int'(bus.pixel_opaque), 0);

      // mid-frame request change is ignored until frame_start
      bus.duck_x = 10'd0;
      cycle(1010, 210, 1'b1, 1'b0);
      chk("tp_midframe", int'(bus.rom_addr), 510);

      // reset during an active hit, then refill
      cycle(1010, 211, 1'b1, 1'b0);
      do_reset();
      bus.duck_x = 10'd100; bus.duck_y = 10'd200; bus.duck_en = 1'b1; bus.duck_mirror = 1'b0;
      cycle(0, 0, 1'b0, 1'b1);
      cycle(100, 200, 1'b1, 1'b0);
      chk("tp_refill_1", int'(bus.pixel_opaque), 0);
      idle();
      chk("tp_refill_2", int'(bus.pixel_opaque), 0);
      idle();
      chk("tp_refill_3", int'(bus.pixel_opaque), 1);

      // randomized frames around the sprite box
      for (int f = 0; f < 40; f++) begin
         bus.duck_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(960, 1023))
                                                  : 10'($urandom_range(0, 1023));
         bus.duck_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(960, 1023))
                                                  : 10'($urandom_range(0, 1023));
         bus.duck_en = ($urandom_range(0, 7) != 0);
         bus.duck_mirror = 1'($urandom_range(0, 1));
         cycle(0, 0, 1'b0, 1'b1);
         for (int c = 0; c < 80; c++) begin
            int xi, yi;
            bit bl, fs;
            xi = (m_lx + int'($urandom_range(0, 60)) - 5) & 1023;
            yi = (m_ly + int'($urandom_range(0, 60)) - 5) & 1023;
            bl = ($urandom_range(0, 9) != 0);
            fs = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 39) == 0) bus.duck_x = 10'($urandom_range(0, 1023));
            cycle(xi, yi, bl, fs);
         end
      end

      idle(); idle(); idle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
